mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/arm_mc_pkg.sv | 60 ++++++
 rtl/mc_controller_if.sv | 21 ++
 rtl/mc_condlogic.sv | 45 ++++
 rtl/mc_controller.sv | 159 +++++++++++++++
 tb/tb_mc_controller.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM state codes, mux
// selects, ALU operations and the condition-code evaluator.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Flags are packed {N, Z, C, V}; condition 1111 never executes.
  function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c && !z;
      4'b1001: cond_ex = !c || z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = !z && (n == v);
      4'b1101: cond_ex = z || (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction/flag inputs and control outputs.
interface mc_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite;
  logic        AdrSrc, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0]  Flags, State;

  // master: the controller; slave: the datapath it steers
  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags, State
  );
  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags, State
  );
endinterface

// File: rtl/mc_condlogic.sv
// Stored NZCV flags, latched condition result and gating of the write strobes.
module mc_condlogic
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       cond_latch,
  input  logic       flag_nz,
  input  logic       flag_cv,
  input  logic       pc_uncond,
  input  logic       pc_cond,
  input  logic       reg_cond,
  input  logic       mem_cond,
  input  logic       ir_req,
  output logic [3:0] flags,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       ir_write
);

  logic cond_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags   <= '0;
      cond_ok <= 1'b0;
    end else begin
      if (cond_latch) cond_ok <= cond_ex(cond, flags);
      if (flag_nz && cond_ok) flags[3:2] <= alu_flags[3:2];
      if (flag_cv && cond_ok) flags[1:0] <= alu_flags[1:0];
    end
  end

  // Reset masks every strobe so an aborted instruction leaves no side effects.
  always_comb begin
    pc_write  = !reset && (pc_uncond || (pc_cond && cond_ok));
    reg_write = !reset && reg_cond && cond_ok;
    mem_write = !reset && mem_cond && cond_ok;
    ir_write  = !reset && ir_req;
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control FSM; condition evaluation and strobe gating live in
// mc_condlogic.
module mc_controller
  import arm_mc_pkg::*;
(
  input logic             clk,
  input logic             reset,
  mc_controller_if.master bus
);

  state_t      state, state_next;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic        unused_instr;

  assign op           = bus.Instr[27:26];
  assign funct        = bus.Instr[25:20];
  assign rd           = bus.Instr[15:12];
  assign unused_instr = &{1'b0, bus.Instr[19:16], bus.Instr[11:0]};

  logic [1:0] alu_dec;
  logic       no_wb, no_flags, cv_upd;

  always_comb begin
    alu_dec  = ALU_ADD;
    no_wb    = 1'b0;
    no_flags = 1'b0;
    cv_upd   = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_dec = ALU_ADD; cv_upd = 1'b1; end
      4'b0010: begin alu_dec = ALU_SUB; cv_upd = 1'b1; end
      4'b0000: alu_dec = ALU_AND;
      4'b1100: alu_dec = ALU_ORR;
      4'b1010: begin alu_dec = ALU_SUB; cv_upd = 1'b1; no_wb = 1'b1; end
      default: begin no_wb = 1'b1; no_flags = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_MEM:  state_next = MEMADR;
          OP_DP:   state_next = funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_next = BRANCH;
          default: state_next = UNKNOWN;
        endcase
      end
      MEMADR:   state_next = funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_next = MEMWB;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      default:  state_next = FETCH;
    endcase
  end

  logic       cond_latch, flag_nz, flag_cv;
  logic       pc_uncond, pc_cond, reg_cond, mem_cond, ir_req;
  logic       adr_src, alu_src_a;
  logic [1:0] result_src, alu_src_b, alu_control;

  always_comb begin
    cond_latch  = 1'b0;
    flag_nz     = 1'b0;
    flag_cv     = 1'b0;
    pc_uncond   = 1'b0;
    pc_cond     = 1'b0;
    reg_cond    = 1'b0;
    mem_cond    = 1'b0;
    ir_req      = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_b   = SRCB_REG;
    alu_control = ALU_ADD;
    case (state)
      FETCH: begin
        ir_req     = 1'b1;
        pc_uncond  = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      DECODE: begin
        cond_latch = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      MEMADR:   alu_src_b = SRCB_IMM;
      MEMRD:    adr_src   = 1'b1;
      MEMWB: begin
        result_src = RES_DATA;
        reg_cond   = 1'b1;
      end
      MEMWR: begin
        adr_src  = 1'b1;
        mem_cond = 1'b1;
      end
      EXECUTER, EXECUTEI: begin
        alu_src_b   = (state == EXECUTEI) ? SRCB_IMM : SRCB_REG;
        alu_control = alu_dec;
        flag_nz     = funct[0] && !no_flags;
        flag_cv     = funct[0] && cv_upd;
      end
      ALUWB: begin
        // A result destined for R15 becomes a PC write instead of a register write.
        if (!no_wb) begin
          if (rd == 4'd15) pc_cond  = 1'b1;
          else             reg_cond = 1'b1;
        end
      end
      BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_cond    = 1'b1;
      end
      default: ;
    endcase
  end

  mc_condlogic u_condlogic (
    .clk        (clk),
    .reset      (reset),
    .cond       (bus.Instr[31:28]),
    .alu_flags  (bus.ALUFlags),
    .cond_latch (cond_latch),
    .flag_nz    (flag_nz),
    .flag_cv    (flag_cv),
    .pc_uncond  (pc_uncond),
    .pc_cond    (pc_cond),
    .reg_cond   (reg_cond),
    .mem_cond   (mem_cond),
    .ir_req     (ir_req),
    .flags      (bus.Flags),
    .pc_write   (bus.PCWrite),
    .reg_write  (bus.RegWrite),
    .mem_write  (bus.MemWrite),
    .ir_write   (bus.IRWrite)
  );

  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
  assign bus.State      = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through the
// FSM and compares states, strobes and selects against hand-derived values.
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {PCWrite, MemWrite, RegWrite, IRWrite}
  logic [3:0] strobes;
  assign strobes = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.Instr = 32'hE2802005;
    bus.ALUFlags = 4'b0000;
    tick();
    vectors++; if (bus.State !== 4'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", bus.State); end
    vectors++; if (bus.Flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b expected 0000", bus.Flags); end
    vectors++; if (strobes !== 4'b0000) begin miscompares++; $display("FAIL reset_strobes: got %b expected 0000", strobes); end
    reset = 1'b0;
    #1;
    vectors++; if (strobes !== 4'b1001) begin miscompares++; $display("FAIL fetch_strobes: got %b expected 1001", strobes); end
    vectors++; if ({bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc} !== 6'b01_10_10) begin
      miscompares++; $display("FAIL fetch_selects: got %b expected 011010", {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc}); end
  endtask

  task automatic test_addi;
    bus.Instr = 32'hE2802005;
    tick();
    vectors++; if (bus.State !== 4'd1) begin miscompares++; $display("FAIL addi_decode_state: got %0d expected 1", bus.State); end
    vectors++; if (strobes !== 4'b0000) begin miscompares++; $display("FAIL addi_decode_strobes: got %b expected 0000", strobes); end
    tick();
    vectors++; if (bus.State !== 4'd7) begin miscompares++; $display("FAIL addi_exec_state: got %0d expected 7", bus.State); end
    vectors++; if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl} !== 5'b0_01_00) begin
      miscompares++; $display("FAIL addi_exec_selects: got %b expected 00100", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl}); end
    vectors++; if (strobes !== 4'b0000) begin miscompares++; $display("FAIL addi_exec_strobes: got %b expected 0000", strobes); end
    tick();
    vectors++; if (bus.State !== 4'd8) begin miscompares++; $display("FAIL addi_wb_state: got %0d expected 8", bus.State); end
    vectors++; if (strobes !== 4'b0010) begin miscompares++; $display("FAIL addi_wb_strobes: got %b expected 0010", strobes); end
    tick();
    vectors++; if (bus.State !== 4'd0) begin miscompares++; $display("FAIL addi_return: got %0d expected 0", bus.State); end
  endtask

  task automatic test_subs;
    bus.Instr = 32'hE0513001;
    tick();
    tick();
    vectors++; if (bus.State !== 4'd6) begin miscompares++; $display("FAIL subs_exec_state: got %0d expected 6", bus.State); end
    vectors++; if ({bus.ALUSrcB, bus.ALUControl} !== 4'b00_01) begin
      miscompares++; $display("FAIL subs_exec_selects: got %b expected 0001", {bus.ALUSrcB, bus.ALUControl}); end
    bus.ALUFlags = 4'b0110;
    tick();
    bus.ALUFlags = 4'b0000;
    vectors++; if (bus.Flags !== 4'b0110) begin miscompares++; $display("FAIL subs_flags: got %b expected 0110", bus.Flags); end
    vectors++; if (strobes !== 4'b0010) begin miscompares++; $display("FAIL subs_wb_strobes: got %b expected 0010", strobes); end
    tick();
    vectors++; if (bus.Flags !== 4'b0110) begin miscompares++; $display("FAIL subs_flags_hold: got %b expected 0110", bus.Flags); end
  endtask

  task automatic test_branch;
    bus.Instr = 32'h0A000002;
    tick();
    tick();
    vectors++; if (bus.State !== 4'd9) begin miscompares++; $display("FAIL beq_state: got %0d expected 9", bus.State); end
    vectors++; if (strobes !== 4'b1000) begin miscompares++; $display("FAIL beq_strobes: got %b expected 1000", strobes); end
    vectors++; if ({bus.ALUSrcB, bus.ResultSrc, bus.RegSrc, bus.ImmSrc} !== 8'b01_10_01_10) begin
      miscompares++; $display("FAIL beq_selects: got %b expected 01100110", {bus.ALUSrcB, bus.ResultSrc, bus.RegSrc, bus.ImmSrc}); end
    tick();
    vectors++; if (bus.State !== 4'd0) begin miscompares++; $display("FAIL beq_return: got %0d expected 0", bus.State); end
    bus.Instr = 32'h1A000002;
    tick();
    tick();
    vectors++; if (strobes !== 4'b0000) begin miscompares++; $display("FAIL bne_strobes: got %b expected 0000", strobes); end
    tick();
    vectors++; if (bus.State !== 4'd0) begin miscompares++; $display("FAIL bne_return: got %0d expected 0", bus.State); end
  endtask

  task automatic test_ldr_str;
    bus.Instr = 32'hE5904008;
    tick();
    tick();
    vectors++; if (bus.State !== 4'd2) begin miscompares++; $display("FAIL ldr_memadr_state: got %0d expected 2", bus.State); end
    vectors++; if ({bus.ALUSrcA, bus.ALUSrcB, bus.RegSrc, strobes} !== 9'b0_01_10_0000) begin
      miscompares++; $display("FAIL ldr_memadr_out: got %b expected 001100000", {bus.ALUSrcA, bus.ALUSrcB, bus.RegSrc, strobes}); end
    tick();
    vectors++; if ({bus.State, bus.AdrSrc, strobes} !== {4'd3, 1'b1, 4'b0000}) begin
      miscompares++; $display("FAIL ldr_memrd: got %b expected 001110000", {bus.State, bus.AdrSrc, strobes}); end
    tick();
    vectors++; if ({bus.State, bus.ResultSrc, strobes} !== {4'd4, 2'b01, 4'b0010}) begin
      miscompares++; $display("FAIL ldr_memwb: got %b expected 0100010010", {bus.State, bus.ResultSrc, strobes}); end
    tick();
    vectors++; if (bus.State !== 4'd0) begin miscompares++; $display("FAIL ldr_return: got %0d expected 0", bus.State); end
    bus.Instr = 32'hE5804008;
    tick();
    tick();
    vectors++; if (strobes !== 4'b0000) begin miscompares++; $display("FAIL str_memadr_strobes: got %b expected 0000", strobes); end
    tick();
    vectors++; if ({bus.State, bus.AdrSrc, strobes} !== {4'd5, 1'b1, 4'b0100}) begin
      miscompares++; $display("FAIL str_memwr: got %b expected 010110100", {bus.State, bus.AdrSrc, strobes}); end
    tick();
    vectors++; if (bus.State !== 4'd0) begin miscompares++; $display("FAIL str_return: got %0d expected 0", bus.State); end
  endtask

  task automatic test_dp_special;
    bus.Instr = 32'hE1510001;  // CMP R1,R1
    tick();
    tick();
    vectors++; if (bus.ALUControl !== 2'b01) begin miscompares++; $display("FAIL cmp_alucontrol: got %b expected 01", bus.ALUControl); end
    bus.ALUFlags = 4'b1001;
    tick();
    bus.ALUFlags = 4'b0000;
    vectors++; if (strobes !== 4'b0000) begin miscompares++; $display("FAIL cmp_wb_strobes: got %b expected 0000", strobes); end
    vectors++; if (bus.Flags !== 4'b1001) begin miscompares++; $display("FAIL cmp_flags: got %b expected 1001", bus.Flags); end
    tick();
    bus.Instr = 32'hE28FF004;  // ADD PC,PC,#4
    tick();
    tick();
    tick();
    vectors++; if (strobes !== 4'b1000) begin miscompares++; $display("FAIL add_pc_wb_strobes: got %b expected 1000", strobes); end
    tick();
    bus.Instr = 32'hF2802005;  // cond=1111 never executes
    tick();
    tick();
    tick();
    vectors++; if (strobes !== 4'b0000) begin miscompares++; $display("FAIL nv_wb_strobes: got %b expected 0000", strobes); end
    tick();
    vectors++; if (bus.State !== 4'd0) begin miscompares++; $display("FAIL nv_return: got %0d expected 0", bus.State); end
  endtask

  task automatic test_unknown;
    bus.Instr = 32'hEC000000;
    tick();
    vectors++; if ({bus.State, strobes} !== {4'd1, 4'b0000}) begin
      miscompares++; $display("FAIL unk_decode: got %b expected 00010000", {bus.State, strobes}); end
    tick();
    vectors++; if ({bus.State, strobes} !== {4'd10, 4'b0000}) begin
      miscompares++; $display("FAIL unk_state: got %b expected 10100000", {bus.State, strobes}); end
    tick();
    vectors++; if ({bus.State, strobes} !== {4'd0, 4'b1001}) begin
      miscompares++; $display("FAIL unk_return: got %b expected 00001001", {bus.State, strobes}); end
  endtask

  task automatic test_reset_mid;
    bus.Instr = 32'hE5904008;
    tick();
    tick();
    tick();
    vectors++; if (bus.State !== 4'd3) begin miscompares++; $display("FAIL rst_mid_memrd: got %0d expected 3", bus.State); end
    reset = 1'b1;
    #1;
    vectors++; if (strobes !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_strobes: got %b expected 0000", strobes); end
    tick();
    vectors++; if (bus.State !== 4'd0) begin miscompares++; $display("FAIL rst_mid_state: got %0d expected 0", bus.State); end
    vectors++; if (bus.Flags !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_flags: got %b expected 0000", bus.Flags); end
    vectors++; if (strobes !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_hold_strobes: got %b expected 0000", strobes); end
    reset = 1'b0;
    #1;
    vectors++; if (strobes !== 4'b1001) begin miscompares++; $display("FAIL rst_mid_refetch: got %b expected 1001", strobes); end
    tick();
    vectors++; if ({bus.State, strobes} !== {4'd1, 4'b0000}) begin
      miscompares++; $display("FAIL rst_mid_decode: got %b expected 00010000", {bus.State, strobes}); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_subs();
    test_branch();
    test_ldr_str();
    test_dp_special();
    test_unknown();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
